// File: rtl/synchronous_fifo_counted_if.sv
// Producer/consumer bundle for the counted synchronous FIFO.
// The master side drives requests; the slave side is the FIFO itself.
interface synchronous_fifo_counted_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  push;
  logic                  poll;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, poll, flush, clr_err, data_in,
    input  head, tail, count, full, empty,
    input  almost_full, almost_empty,
    input  overflow, underflow
  );

  modport slave (
    input  push, poll, flush, clr_err, data_in,
    output head, tail, count, full, empty,
    output almost_full, almost_empty,
    output overflow, underflow
  );
endinterface

// File: rtl/synchronous_fifo_counted.sv
// Single-clock FIFO with registered occupancy count, threshold flags,
// flush and sticky overflow/underflow; DEPTH need not be a power of two.
module synchronous_fifo_counted #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input logic clk,
  input logic rst,
  synchronous_fifo_counted_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] w_ptr, r_ptr;
  logic [PW-1:0] w_nxt, r_nxt, t_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_w, empty_w;
  logic          push_acc, poll_acc;
  logic          ovf_q, unf_q;
  logic          ovf_set, unf_set;

  assign full_w  = (cnt_q == CW'(DEPTH));
  assign empty_w = (cnt_q == '0);

  // A full FIFO still accepts a push when a poll frees the head slot.
  assign poll_acc = bus.poll & ~empty_w;
  assign push_acc = bus.push & (~full_w | bus.poll);

  assign w_nxt = (w_ptr == LAST) ? '0 : w_ptr + PW'(1);
  assign r_nxt = (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
  assign t_idx = (w_ptr == '0) ? LAST : w_ptr - PW'(1);

  assign cnt_d = cnt_q + CW'(push_acc) - CW'(poll_acc);

  assign ovf_set = ~bus.flush & bus.push & ~push_acc;
  assign unf_set = ~bus.flush & bus.poll & empty_w & ~bus.push;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt_q <= '0;
    end else if (bus.flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt_q <= '0;
    end else begin
      if (push_acc) w_ptr <= w_nxt;
      if (poll_acc) r_ptr <= r_nxt;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q <= unf_set | (unf_q & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push_acc) mem[w_ptr] <= bus.data_in;
  end

  assign bus.count        = cnt_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (cnt_q <= CW'(AE_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.head         = empty_w ? '0 : mem[r_ptr];
  assign bus.tail         = empty_w ? '0 : mem[t_idx];
endmodule

// File: tb/tb_synchronous_fifo_counted.sv
// Directed bench for synchronous_fifo_counted at DEPTH=8 and DEPTH=5,
// with queue scoreboards checked by per-instance head monitors.
module tb_synchronous_fifo_counted;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  synchronous_fifo_counted_if #(.DEPTH(8), .DATA_WIDTH(8)) ia ();
  synchronous_fifo_counted_if #(.DEPTH(5), .DATA_WIDTH(8)) ib ();

  synchronous_fifo_counted #(.DEPTH(8), .DATA_WIDTH(8)) ua (
    .clk(clk), .rst(rst), .bus(ia)
  );
  synchronous_fifo_counted #(.DEPTH(5), .DATA_WIDTH(8)) ub (
    .clk(clk), .rst(rst), .bus(ib)
  );

  logic [7:0] qa [$];
  logic [7:0] qb [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitors: every accepted poll must present the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !ia.flush && ia.poll && !ia.empty) begin
      if (qa.size() == 0) chk("a_pop_unexpected", 32'(ia.head), 32'hdead);
      else chk("a_head_order", 32'(ia.head), 32'(qa.pop_front()));
    end
    if (!rst && !ib.flush && ib.poll && !ib.empty) begin
      if (qb.size() == 0) chk("b_pop_unexpected", 32'(ib.head), 32'hdead);
      else chk("b_head_order", 32'(ib.head), 32'(qb.pop_front()));
    end
  end

  task automatic cyc_a(input logic pu, input logic po, input logic fl,
                       input logic ce, input logic [7:0] d,
                       input logic exp_acc);
    ia.push = pu; ia.poll = po; ia.flush = fl;
    ia.clr_err = ce; ia.data_in = d;
    if (fl) qa.delete();
    if (exp_acc) qa.push_back(d);
    @(posedge clk); #1;
    ia.push = 0; ia.poll = 0; ia.flush = 0; ia.clr_err = 0;
  endtask

  task automatic cyc_b(input logic pu, input logic po,
                       input logic [7:0] d, input logic exp_acc);
    ib.push = pu; ib.poll = po; ib.data_in = d;
    if (exp_acc) qb.push_back(d);
    @(posedge clk); #1;
    ib.push = 0; ib.poll = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.push = 0; ia.poll = 0; ia.flush = 0; ia.clr_err = 0; ia.data_in = 0;
    ib.push = 0; ib.poll = 0; ib.flush = 0; ib.clr_err = 0; ib.data_in = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", 32'(ia.count), 0);
    chk("rst_empty", 32'(ia.empty), 1);
    chk("rst_full", 32'(ia.full), 0);
    chk("rst_ae", 32'(ia.almost_empty), 1);
    chk("rst_af", 32'(ia.almost_full), 0);
    chk("rst_ovf", 32'(ia.overflow), 0);
    chk("rst_unf", 32'(ia.underflow), 0);
    chk("rst_head", 32'(ia.head), 0);
    chk("rst_tail", 32'(ia.tail), 0);

    // Fill DEPTH=8 with 0x11..0x18
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1, 0, 0, 0, 8'(8'h10 + i), 1);
      chk("fill_count", 32'(ia.count), 32'(i));
      chk("fill_af", 32'(ia.almost_full), (i >= 7) ? 1 : 0);
      chk("fill_ae", 32'(ia.almost_empty), (i <= 1) ? 1 : 0);
      chk("fill_tail", 32'(ia.tail), 32'(8'h10 + i));
    end
    chk("fill_full", 32'(ia.full), 1);
    chk("fill_head", 32'(ia.head), 32'h11);

    // Push into full FIFO alone
    cyc_a(1, 0, 0, 0, 8'hAA, 0);
    chk("ovf_set", 32'(ia.overflow), 1);
    chk("ovf_count", 32'(ia.count), 8);
    chk("ovf_tail", 32'(ia.tail), 32'h18);
    cyc_a(0, 0, 0, 1, 8'h00, 0);
    chk("ovf_clr", 32'(ia.overflow), 0);

    // Push + poll while full
    cyc_a(1, 1, 0, 0, 8'hBB, 1);
    chk("pp_full_count", 32'(ia.count), 8);
    chk("pp_full_head", 32'(ia.head), 32'h12);
    chk("pp_full_tail", 32'(ia.tail), 32'hBB);
    chk("pp_full_ovf", 32'(ia.overflow), 0);

    // Drain
    for (int i = 0; i < 8; i++) cyc_a(0, 1, 0, 0, 8'h00, 0);
    chk("drain_empty", 32'(ia.empty), 1);
    chk("drain_count", 32'(ia.count), 0);

    // Poll while empty
    cyc_a(0, 1, 0, 0, 8'h00, 0);
    chk("unf_set", 32'(ia.underflow), 1);
    chk("unf_head", 32'(ia.head), 0);
    chk("unf_empty", 32'(ia.empty), 1);

    // clr_err together with a new underflow: set wins
    cyc_a(0, 1, 0, 1, 8'h00, 0);
    chk("unf_set_wins", 32'(ia.underflow), 1);
    cyc_a(0, 0, 0, 1, 8'h00, 0);
    chk("unf_clr", 32'(ia.underflow), 0);

    // Push + poll while empty accepts only the push
    cyc_a(1, 1, 0, 0, 8'h33, 1);
    chk("pp_empty_count", 32'(ia.count), 1);
    chk("pp_empty_unf", 32'(ia.underflow), 0);
    chk("pp_empty_head", 32'(ia.head), 32'h33);
    cyc_a(0, 1, 0, 0, 8'h00, 0);

    // Flush with a coincident push
    for (int i = 1; i <= 4; i++) cyc_a(1, 0, 0, 0, 8'(8'h40 + i), 1);
    chk("pre_flush_count", 32'(ia.count), 4);
    cyc_a(1, 0, 1, 0, 8'h99, 0);
    chk("flush_count", 32'(ia.count), 0);
    chk("flush_empty", 32'(ia.empty), 1);
    chk("flush_ovf", 32'(ia.overflow), 0);
    chk("flush_head", 32'(ia.head), 0);
    cyc_a(1, 0, 0, 0, 8'h5A, 1);
    chk("post_flush_head", 32'(ia.head), 32'h5A);
    chk("post_flush_tail", 32'(ia.tail), 32'h5A);
    chk("post_flush_count", 32'(ia.count), 1);
    cyc_a(0, 1, 0, 0, 8'h00, 0);

    // DEPTH=5: alternate push/poll so pointers wrap twice
    for (int i = 0; i < 12; i++) begin
      cyc_b(1, 0, 8'(8'h60 + i), 1);
      chk("b_alt_tail", 32'(ib.tail), 32'(8'h60 + i));
      chk("b_alt_count", 32'(ib.count), 1);
      cyc_b(0, 1, 8'h00, 0);
      chk("b_alt_empty", 32'(ib.empty), 1);
    end

    // DEPTH=5 fill across the wrapped pointers
    for (int i = 1; i <= 5; i++) begin
      cyc_b(1, 0, 8'(8'h80 + i), 1);
      chk("b_fill_af", 32'(ib.almost_full), (i >= 4) ? 1 : 0);
    end
    chk("b_full", 32'(ib.full), 1);
    chk("b_head", 32'(ib.head), 32'h81);
    chk("b_tail", 32'(ib.tail), 32'h85);
    cyc_b(1, 1, 8'h86, 1);
    chk("b_pp_count", 32'(ib.count), 5);
    chk("b_pp_tail", 32'(ib.tail), 32'h86);
    for (int i = 0; i < 5; i++) cyc_b(0, 1, 8'h00, 0);
    chk("b_drained", 32'(ib.empty), 1);

    @(posedge clk); #1;
    chk("a_queue_left", 32'(qa.size()), 0);
    chk("b_queue_left", 32'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/synchronous_fifo_counted.md
# synchronous_fifo_counted

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags, flush, and sticky overflow/underflow error flags. It is the next generation of the team's synchronous FIFO. All DEPTH entries are usable, DEPTH need not be a power of two, and a push into a full FIFO is accepted when it coincides with a poll. It sits between producer/consumer stages of the core (fetch queues, writeback buffers) where flow-control thresholds and error visibility are needed.

## Interface
Parameters:
- DEPTH, 8, number of entries; any integer ≥ 2.
- DATA_WIDTH, 8, entry width in bits.
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request; data_in is written if accepted.
- poll  in  1  read request; removes head if accepted.
- flush  in  1  synchronous clear of contents; does not clear error flags.
- clr_err  in  1  clears overflow/underflow.
- data_in  in  DATA_WIDTH  write data.
- head  out  DATA_WIDTH  oldest entry; 0 when empty.
- tail  out  DATA_WIDTH  newest entry; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full, empty  out  1  count==DEPTH, count==0.
- almost_full, almost_empty  out  1  threshold flags as above.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Storage: DEPTH×DATA_WIDTH array. Write pointer w_ptr and read pointer r_ptr each range 0..DEPTH-1 and wrap from DEPTH-1 to 0; no power-of-two masking.
- Occupancy is held in a registered count. full/empty/almost flags are decoded from count only, with no combinational path from push/poll/data_in.
- poll_acc = poll & !empty.
- push_acc = push & (!full | poll). When full, a simultaneous push+poll is accepted: head is removed, data_in is written, and count is unchanged.
- When empty, a push+poll accepts the push and ignores the poll. This is not an underflow; there is no bypass.
- count_next = count + push_acc - poll_acc.
- Priority per cycle: rst > flush > push/poll.
- flush: w_ptr, r_ptr and count go to 0, and push/poll in the same cycle are ignored. Array contents are not cleared. overflow/underflow are unaffected, but no error is raised that cycle.
- overflow is set when push & !push_acc (and not flush). underflow is set when poll & empty & !push (and not flush). Both hold until rst or clr_err.
- If clr_err coincides with a new error event, the flag ends set (set wins).
- head = array[r_ptr] when !empty, else 0.
- tail = array[w_ptr==0 ? DEPTH-1 : w_ptr-1] when !empty, else 0.

## Timing
- Reset values after rst:
  - Pointers 0, count 0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - head=0, tail=0.
  - Array contents are unspecified.
- Latency: data pushed in cycle N appears on tail, and on head if the FIFO was empty, after posedge N+1. count and flags update on the same edge.
- A poll in cycle N advances head after posedge N+1.
- Throughput: one push and one poll per cycle, sustained, at any occupancy.
- rst or flush asserted mid-stream takes effect at that edge. A push in the same cycle is dropped and does not raise overflow.

## Test plan
- Reset, then push 0x11..0x18 (DEPTH=8) on consecutive cycles -> count steps 1..8, full=1 after the 8th edge, almost_full=1 from count 7, head=0x11, tail=0x18.
- From full, push 0xAA alone -> not written, overflow=1, count stays 8. Then clr_err -> overflow=0.
- From full, push 0xBB + poll in the same cycle -> count 8, head=0x12, tail=0xBB, no overflow.
- Drain to empty, then poll -> underflow=1, head=0, empty=1. Push+poll while empty -> count=1, no underflow.
- DEPTH=5: push and poll alternately for 12 entries -> pointers wrap and data order is preserved.
- With count=4, assert flush together with push -> count=0, empty=1, no overflow; a later push of 0x5A gives head=tail=0x5A.
